// File: rtl/yuv444_to_yuv422.sv
// 4:4:4 to 4:2:2 chroma subsampler: Y every pixel, Cb/Cr alternating per pixel.
// Two register stages; even pixels pair with the following odd pixel inside a DE run.
module yuv444_to_yuv422 #(
  parameter int unsigned C_BPC      = 8,
  parameter int unsigned C_FILTER   = 1,
  parameter int unsigned C_CB_FIRST = 1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             DE_I,
  input  logic             HS_I,
  input  logic             VS_I,
  input  logic [C_BPC-1:0] Y_I,
  input  logic [C_BPC-1:0] U_I,
  input  logic [C_BPC-1:0] V_I,
  output logic             DE_O,
  output logic             HS_O,
  output logic             VS_O,
  output logic [C_BPC-1:0] Y_O,
  output logic [C_BPC-1:0] C_O
);

  localparam logic PH_EVEN = 1'b0;
  localparam logic PH_ODD  = 1'b1;

  logic             phase_q, phase_d;
  logic             odd1_q, odd1_d;
  logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [C_BPC-1:0] y1_q, y1_d, u1_q, u1_d, v1_q, v1_d;

  logic             de_o_q, de_o_d, hs_o_q, hs_o_d, vs_o_q, vs_o_d;
  logic [C_BPC-1:0] y_o_q, y_o_d, c_o_q, c_o_d, held_q, held_d;

  logic [C_BPC-1:0] cb, cr;

  always_comb begin
    phase_d = DE_I ? ((phase_q == PH_EVEN) ? PH_ODD : PH_EVEN) : PH_EVEN;
    odd1_d  = DE_I && (phase_q == PH_ODD);
    de1_d   = DE_I;
    hs1_d   = HS_I;
    vs1_d   = VS_I;
    y1_d    = Y_I;
    u1_d    = U_I;
    v1_d    = V_I;
  end

  // Stage 1 holds the even pixel; the live input is its odd partner when DE_I is high.
  always_comb begin
    if ((C_FILTER != 0) && DE_I) begin
      cb = C_BPC'(({1'b0, u1_q} + {1'b0, U_I} + (C_BPC+1)'(1)) >> 1);
      cr = C_BPC'(({1'b0, v1_q} + {1'b0, V_I} + (C_BPC+1)'(1)) >> 1);
    end else begin
      cb = u1_q;
      cr = v1_q;
    end
  end

  always_comb begin
    de_o_d = de1_q;
    hs_o_d = hs1_q;
    vs_o_d = vs1_q;
    y_o_d  = '0;
    c_o_d  = '0;
    held_d = held_q;
    if (de1_q) begin
      y_o_d = y1_q;
      if (odd1_q) begin
        c_o_d = held_q;
      end else begin
        c_o_d  = (C_CB_FIRST != 0) ? cb : cr;
        held_d = (C_CB_FIRST != 0) ? cr : cb;
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      phase_q <= PH_EVEN;
      odd1_q  <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      y1_q    <= '0;
      u1_q    <= '0;
      v1_q    <= '0;
      de_o_q  <= 1'b0;
      hs_o_q  <= 1'b0;
      vs_o_q  <= 1'b0;
      y_o_q   <= '0;
      c_o_q   <= '0;
      held_q  <= '0;
    end else begin
      phase_q <= phase_d;
      odd1_q  <= odd1_d;
      de1_q   <= de1_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      y1_q    <= y1_d;
      u1_q    <= u1_d;
      v1_q    <= v1_d;
      de_o_q  <= de_o_d;
      hs_o_q  <= hs_o_d;
      vs_o_q  <= vs_o_d;
      y_o_q   <= y_o_d;
      c_o_q   <= c_o_d;
      held_q  <= held_d;
    end
  end

  assign DE_O = de_o_q;
  assign HS_O = hs_o_q;
  assign VS_O = vs_o_q;
  assign Y_O  = y_o_q;
  assign C_O  = c_o_q;

endmodule

// File: doc/yuv444_to_yuv422.md
Name: yuv444_to_yuv422

Overview:
- Chroma subsampler placed after rgb2yuv on the transmit side of the video path.
- Converts a 4:4:4 YUV pixel stream with DE/HS/VS timing into a 4:2:2 stream: Y on every pixel, one chroma sample per pixel alternating Cb/Cr.
- Its counterpart is the 4:2:2→4:4:4 upsampler that feeds yuv2rgb on the receive side.
- Fixed latency, no backpressure, one pixel per clock.

Parameters:
- C_BPC, 8, bits per component.
- C_FILTER, 1, chroma decimation mode: 1 = average the pixel pair (rounded), 0 = take the even pixel's chroma (drop the odd one).
- C_CB_FIRST, 1, chroma order: 1 = even pixel carries Cb and odd carries Cr; 0 = swapped.

Ports:
- CLK_I  input  1  pixel clock
- RST_I  input  1  reset, asynchronous, active-low
- DE_I  input  1  active video
- HS_I  input  1  hsync, passed through
- VS_I  input  1  vsync, passed through
- Y_I  input  C_BPC  luma
- U_I  input  C_BPC  Cb
- V_I  input  C_BPC  Cr
- DE_O  output  1  DE_I delayed 2 clocks
- HS_O  output  1  HS_I delayed 2 clocks
- VS_O  output  1  VS_I delayed 2 clocks
- Y_O  output  C_BPC  luma, delayed 2 clocks
- C_O  output  C_BPC  interleaved chroma

Behaviour:
- Reset (RST_I=0, async):
  - All outputs and pipeline registers go to 0; phase = EVEN.
  - Mid-frame reset discards any held pixel. The first pixel accepted after release is phase EVEN.
- Latency: exactly 2 clocks from an input sample to the corresponding output, for every signal. DE_O, HS_O and VS_O stay cycle-aligned with Y_O and C_O.
- Phase state machine, 2 states, EVEN and ODD:
  - Updated only on cycles with DE_I=1: EVEN→ODD, ODD→EVEN.
  - DE_I=0 forces EVEN. Each line therefore starts EVEN on the DE rising edge, and a DE gap mid-line ends the current pair.
- Pairing: an EVEN pixel P0 is held one clock.
  - Next cycle, DE_I=1 (ODD pixel P1 present), C_FILTER=1:
    - cb = (U0+U1+1)>>1
    - cr = (V0+V1+1)>>1
    - Sums use C_BPC+1 bits; the result never exceeds 2^C_BPC-1, so no saturation logic.
  - Next cycle, DE_I=1, C_FILTER=0: cb = U0, cr = V0.
  - Next cycle, DE_I=0 (odd-length line, unpaired P0): cb = U0, cr = V0 regardless of C_FILTER. Only P0 is output; no phantom pixel is generated.
- Output assignment:
  - P0 emerges with Y0 and C_O = cb (C_CB_FIRST=1) or cr (C_CB_FIRST=0).
  - P1 emerges the next clock with Y1 and the other chroma value, registered at pair time.
- Blanking: when DE_O=0, Y_O=0 and C_O=0. HS_O and VS_O are delayed unmodified regardless of DE.
- HS_I/VS_I edges have no effect on phase. Only DE_I drives phase.
- No dependence on line length; any line length ≥1 is supported, including single-pixel lines.

Test Plan:
- Reset: hold RST_I=0 with DE_I=1 and random data → all outputs 0. Release, then Y=10,20, U=100,50, V=200,0 with C_FILTER=1, C_CB_FIRST=1 → 2 clocks later: (Y_O,C_O)=(10,75), then (20,100), DE_O=1 for both.
- Rounding/extremes: U pair 255,254 and V pair 0,1 → Cb=255, Cr=1. U pair 255,255 → Cb=255 (no overflow).
- Odd-length line of 3 pixels, U=V=40,60,90 → outputs C_O=50,50,90; DE_O high exactly 3 clocks. The next line restarts EVEN (first C_O is Cb).
- C_FILTER=0 and C_CB_FIRST=0 with U=100,50 and V=200,0 → C_O = 200 then 100.
- DE gap: DE pattern 1,1,1,0,1,1 → phase restarts after the gap. The 3rd pixel is emitted as unpaired. Output DE_O equals the input pattern delayed 2, and HS_O/VS_O pulses are aligned with it.
- Async reset asserted mid-pair (after P0 only) → outputs 0 immediately without waiting for a clock. After release, the first pixel is treated as EVEN.
